// File: rtl/bayer_pkg.sv
// Shared types and constants for the Bayer-to-grayscale pipeline.
// The Bayer sensor pattern is GRBG, so each 2x2 quad holds G1 R on the even row and B G2 on the odd row.
package bayer_pkg;

    typedef enum logic [1:0] {
        AVG4 = 2'd0,
        GAVG = 2'd1,
        RED  = 2'd2,
        BLUE = 2'd3
    } gray_mode_e;

    // Slot of each Bayer sample inside an assembled quad
    localparam int G1_POS = 0;
    localparam int R_POS  = 1;
    localparam int B_POS  = 2;
    localparam int G2_POS = 3;
    localparam int QUAD_N = 4;

endpackage

// File: rtl/bayer_gray_pipe_line_ram.sv
// Single-port line buffer: combinational read of the old word, synchronous write at the same address.
// Zero-cycle read, one-cycle write; no backpressure.
module line_ram #(
    parameter int DEPTH = 1280,
    parameter int W     = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdat_i,
    output logic [W-1:0]  rdat_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Read-before-write: rdat_o shows the previous row's pixel while this row's pixel is written
    assign rdat_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdat_i;
        end
    end

endmodule

// File: rtl/bayer_gray_pipe.sv
// Bayer (GRBG) raster to half-resolution grayscale; one result per 2x2 quad, emitted 1 cycle after the G2 pixel.
// No backpressure: every in_valid pixel is consumed; stalls are gaps in in_valid.
module bayer_gray_pipe
    import bayer_pkg::*;
#(
    parameter int PIX_W  = 12,
    parameter int LINE_W = 1280,
    parameter int IMG_H  = 960,
    parameter int X_W    = $clog2(LINE_W),
    parameter int Y_W    = $clog2(IMG_H),
    localparam int OX_W  = (X_W > 1) ? X_W - 1 : 1,
    localparam int OY_W  = (Y_W > 1) ? Y_W - 1 : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_sof,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    output logic [OX_W-1:0]  out_x,
    output logic [OY_W-1:0]  out_y,
    output logic             out_eol,
    output logic             frame_done
);

    localparam logic [X_W-1:0] COL_LAST = X_W'(LINE_W - 1);
    localparam logic [Y_W-1:0] ROW_LAST = Y_W'(IMG_H - 1);

    logic [X_W-1:0]   col_q, col_d, col_c;
    logic [Y_W-1:0]   row_q, row_d, row_c;
    logic             synced_q, synced_d;
    logic             restart, accept, emit, last_col, last_row;

    logic [PIX_W-1:0] ram_rd;
    logic [PIX_W-1:0] cur_hold_q, prev_hold_q;
    logic [PIX_W-1:0] quad [QUAD_N];
    logic [PIX_W+1:0] sum4;
    logic [PIX_W:0]   sum2;
    logic [PIX_W-1:0] gray;
    gray_mode_e       mode_e;

    logic             out_valid_q, out_eol_q, frame_done_q;
    logic [PIX_W-1:0] out_data_q;
    logic [OX_W-1:0]  out_x_q;
    logic [OY_W-1:0]  out_y_q;

    // A start-of-frame pixel is always (0,0), whether it arrives in sync or mid-frame
    always_comb begin
        restart  = in_valid & in_sof;
        accept   = in_valid & (synced_q | in_sof);
        col_c    = restart ? '0 : col_q;
        row_c    = restart ? '0 : row_q;
        last_col = (col_c == COL_LAST);
        last_row = (row_c == ROW_LAST);
        emit     = accept & col_c[0] & row_c[0];
    end

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        synced_d = synced_q | restart;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_c + 1'b1;
            end else begin
                col_d = col_c + 1'b1;
                row_d = row_c;
            end
        end
    end

    line_ram #(
        .DEPTH (LINE_W),
        .W     (PIX_W)
    ) u_line_ram (
        .clk    (clk),
        .we_i   (accept),
        .addr_i (col_c),
        .wdat_i (in_data),
        .rdat_o (ram_rd)
    );

    always_comb begin
        quad[G1_POS] = prev_hold_q;
        quad[R_POS]  = ram_rd;
        quad[B_POS]  = cur_hold_q;
        quad[G2_POS] = in_data;
        sum4 = (PIX_W+2)'(quad[G1_POS]) + (PIX_W+2)'(quad[R_POS])
             + (PIX_W+2)'(quad[B_POS])  + (PIX_W+2)'(quad[G2_POS]);
        sum2 = (PIX_W+1)'(quad[G1_POS]) + (PIX_W+1)'(quad[G2_POS]);
        mode_e = gray_mode_e'(mode);
        gray   = '0;
        case (mode_e)
            AVG4:    gray = sum4[PIX_W+1:2];
            GAVG:    gray = sum2[PIX_W:1];
            RED:     gray = quad[R_POS];
            BLUE:    gray = quad[B_POS];
            default: gray = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            synced_q    <= 1'b0;
            cur_hold_q  <= '0;
            prev_hold_q <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            synced_q <= synced_d;
            // Even column: keep this pixel and the one above it for the odd-column quad close
            if (accept && !col_c[0]) begin
                cur_hold_q  <= in_data;
                prev_hold_q <= ram_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= emit;
            out_eol_q    <= emit & last_col;
            frame_done_q <= emit & last_col & last_row;
            if (emit) begin
                out_data_q <= gray;
                out_x_q    <= OX_W'(col_c >> 1);
                out_y_q    <= OY_W'(row_c >> 1);
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_eol    = out_eol_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bayer_gray_pipe.sv
// Directed and randomized frames against a frame-array reference model of the grayscale pipeline.
module tb_bayer_gray_pipe;

    localparam int PIX_W  = 12;
    localparam int LINE_W = 8;
    localparam int IMG_H  = 4;
    localparam int NPIX   = LINE_W * IMG_H;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [PIX_W-1:0]  in_data = '0;
    logic              in_sof = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              out_valid;
    logic [PIX_W-1:0]  out_data;
    logic [1:0]        out_x;
    logic [0:0]        out_y;
    logic              out_eol;
    logic              frame_done;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: the frame as seen so far, plus raster position
    int  img [IMG_H][LINE_W];
    bit  m_synced = 0;
    int  m_col = 0;
    int  m_row = 0;

    bayer_gray_pipe #(
        .PIX_W  (PIX_W),
        .LINE_W (LINE_W),
        .IMG_H  (IMG_H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_eol    (out_eol),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int gray_of(int g1, int r, int b, int g2, int md);
        case (md)
            0:       return (g1 + r + b + g2) / 4;
            1:       return (g1 + g2) / 2;
            2:       return r;
            default: return b;
        endcase
    endfunction

    // One clock of stimulus; outputs are checked 1 time unit after the edge that samples it
    task automatic step(input bit v, input bit s, input int pix, input int md);
        bit e_vld = 0, e_eol = 0, e_fd = 0;
        int e_dat = 0, e_x = 0, e_y = 0, c, r;
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_data  = pix[PIX_W-1:0];
        mode     = md[1:0];
        if (v && (s || m_synced)) begin
            if (s) begin
                m_col = 0;
                m_row = 0;
                m_synced = 1;
            end
            c = m_col;
            r = m_row;
            img[r][c] = pix;
            if (r % 2 == 1 && c % 2 == 1) begin
                e_vld = 1;
                e_dat = gray_of(img[r-1][c-1], img[r-1][c], img[r][c-1], pix, md);
                e_x   = c / 2;
                e_y   = r / 2;
                e_eol = (c == LINE_W - 1);
                e_fd  = e_eol && (r == IMG_H - 1);
            end
            m_col = c + 1;
            if (m_col == LINE_W) begin
                m_col = 0;
                m_row = (r + 1) % IMG_H;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, e_vld);
        chk("out_eol", out_eol, e_eol);
        chk("frame_done", frame_done, e_fd);
        if (e_vld) begin
            chk("out_data", out_data, e_dat);
            chk("out_x", out_x, e_x);
            chk("out_y", out_y, e_y);
        end
    endtask

    task automatic do_reset(input bit v, input int pix);
        @(negedge clk);
        rst = 1'b1;
        in_valid = v;
        in_sof = 1'b0;
        in_data = pix[PIX_W-1:0];
        @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_x", out_x, 0);
        chk("rst_y", out_y, 0);
        chk("rst_eol", out_eol, 0);
        chk("rst_done", frame_done, 0);
        m_synced = 0;
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    function automatic int pix_of(int kind, int c, int r);
        case (kind)
            0:       return 4 * (c + 1) + 16 * r;
            1:       return 4095;
            2:       return (r % 2 == 1 && c % 2 == 1) ? 0 : 1;
            default: return int'($urandom_range(4095));
        endcase
    endfunction

    // Sends npix pixels of a frame starting at (0,0) with in_sof; md<0 picks a random mode per cycle
    task automatic send_frame(input int kind, input int md, input int stall_pct, input int npix);
        int m;
        for (int i = 0; i < npix; i++) begin
            while (int'($urandom_range(99)) < stall_pct) begin
                m = (md < 0) ? int'($urandom_range(3)) : md;
                step(0, 1'($urandom_range(1)), int'($urandom_range(4095)), m);
            end
            m = (md < 0) ? int'($urandom_range(3)) : md;
            step(1, i == 0, pix_of(kind, i % LINE_W, i / LINE_W), m);
        end
    endtask

    initial begin
        do_reset(0, 0);

        // Pixels before any start of frame are discarded
        for (int i = 0; i < 2 * LINE_W; i++) step(1, 0, int'($urandom_range(4095)), 0);

        for (int md = 0; md < 4; md++) send_frame(0, md, 0, NPIX);
        send_frame(1, 0, 0, NPIX);
        send_frame(2, 0, 0, NPIX);
        for (int md = 0; md < 4; md++) send_frame(0, md, 15, NPIX);

        // Mid-frame resync at row1,col2, then a clean frame
        send_frame(3, 0, 0, LINE_W + 2);
        send_frame(3, 1, 0, NPIX);
        send_frame(3, 0, 0, NPIX);

        // Reset while the row1,col1 pixel is presented, then unsynced pixels, then a clean frame
        send_frame(3, 2, 0, LINE_W + 1);
        do_reset(1, 77);
        for (int i = 0; i < LINE_W + 3; i++) step(1, 0, int'($urandom_range(4095)), 0);
        send_frame(3, 3, 0, NPIX);

        for (int f = 0; f < 20; f++) send_frame(3, -1, 20, NPIX);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
